stack_sequencer: RTL and testbench

STACK_SEQUENCER -- requirements
Module: stack_sequencer

---
 rtl/stack_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: byte-serial push/pop engine for an empty-descending stack.
// Latency: req-to-done = beats + 1 cycles with mem_ready tied high; a guard fault gives done one cycle after req.
// Backpressure: each memory beat stalls while mem_ready=0, and the strobes, address and data hold steady meanwhile.
// Optional feature: define STACK_GUARD_EN to range-check sp at acceptance.
//   Guard off: fault is tied low and sp wraps modulo 2^16.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   req/op/wide/wdata        request handshake (op 0=push 1=pop, wide 0=8b 1=16b)
//   rdata/busy/done/fault    pop result, in-flight flag, completion and fault pulses
//   load_sp/sp_in/sp         stack pointer load and observe
//   mem_*                    single-byte memory port, one beat per mem_ready
module stack_sequencer #(
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op,
    input  logic        wide,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    input  logic        load_sp,
    input  logic [15:0] sp_in,
    output logic [15:0] sp,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_LO, RD_HI, DONE} state_t;

`ifdef STACK_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    state_t      r_state;
    logic [15:0] r_sp;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_wide;
    logic        r_we;
    logic        r_re;
    logic        r_busy;
    logic        r_done;
    logic        r_fault;

    logic [15:0] w_sp_inc;
    logic [15:0] w_sp_dec;
    logic [15:0] w_sp_inc2;
    logic [16:0] w_nbytes;
    logic        w_guard_hit;
    logic        w_guard_fault;

    assign w_sp_inc  = r_sp + 16'd1;
    assign w_sp_dec  = r_sp - 16'd1;
    assign w_sp_inc2 = r_sp + 16'd2;
    assign w_nbytes  = wide ? 17'd2 : 17'd1;

    // 17-bit compares so that underflow below 0 and overflow past FFFF are caught.
    // Push: lowest byte written is sp-n+1, which must be >= STACK_LIMIT; rewritten
    // as sp+1 >= n+STACK_LIMIT so it never goes negative.
    // Pop: highest byte read is sp+n, which must not exceed FFFF.
    assign w_guard_hit = op ? (({1'b0, r_sp} + w_nbytes) > 17'h0FFFF)
                            : (({1'b0, r_sp} + 17'd1) < (w_nbytes + {1'b0, STACK_LIMIT}));
    assign w_guard_fault = GUARD_ON & w_guard_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sp        <= 16'hFFFF;
            r_wdata     <= 16'h0000;
            r_rdata     <= 16'h0000;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_wide      <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    if (load_sp) begin
                        r_sp <= sp_in;
                    end else if (req) begin
                        r_wide  <= wide;
                        r_wdata <= wdata;
                        r_busy  <= 1'b1;
                        if (w_guard_fault) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else if (op) begin
                            r_state    <= RD_LO;
                            r_re       <= 1'b1;
                            r_mem_addr <= w_sp_inc;
                        end else if (wide) begin
                            r_state     <= WR_HI;
                            r_we        <= 1'b1;
                            r_mem_addr  <= r_sp;
                            r_mem_wdata <= wdata[15:8];
                        end else begin
                            r_state     <= WR_LO;
                            r_we        <= 1'b1;
                            r_mem_addr  <= r_sp;
                            r_mem_wdata <= wdata[7:0];
                        end
                    end
                end
                WR_HI: begin
                    if (mem_ready) begin
                        r_sp        <= w_sp_dec;
                        r_mem_addr  <= w_sp_dec;
                        r_mem_wdata <= r_wdata[7:0];
                        r_state     <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (mem_ready) begin
                        r_sp    <= w_sp_dec;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                RD_LO: begin
                    if (mem_ready) begin
                        r_rdata[7:0] <= mem_rdata;
                        r_sp         <= w_sp_inc;
                        if (r_wide) begin
                            r_mem_addr <= w_sp_inc2;
                            r_state    <= RD_HI;
                        end else begin
                            r_rdata[15:8] <= 8'h00;
                            r_re          <= 1'b0;
                            r_done        <= 1'b1;
                            r_state       <= DONE;
                        end
                    end
                end
                RD_HI: begin
                    if (mem_ready) begin
                        r_rdata[15:8] <= mem_rdata;
                        r_sp          <= w_sp_inc;
                        r_re          <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_re    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fault     = r_fault;
    assign sp        = r_sp;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_we;
    assign mem_re    = r_re;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed-vector bench for stack_sequencer with a byte memory model.
// Latency: each operation is timed from req to the done pulse and compared with a hand-computed count.
// Backpressure: mem_ready is driven by the bench, held low for the stall sequence and high otherwise.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        op;
    logic        wide;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic        load_sp;
    logic [15:0] sp_in;
    logic [15:0] sp;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    logic [7:0] mem [0:65535] = '{default: 8'h00};

    int n_cmp  = 0;
    int n_fail = 0;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .wide(wide),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .fault(fault),
        .load_sp(load_sp), .sp_in(sp_in), .sp(sp),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        bit          ld;
        logic [15:0] ld_val;
        logic        op;
        logic        wide;
        logic [15:0] wdata;
        logic [15:0] exp_sp;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        load_sp = 1'b1;
        sp_in   = v;
        tick();
        load_sp = 1'b0;
    endtask

    // Issues one request and waits (bounded) for done; reports latency and flags seen.
    task automatic do_op(input logic o, input logic w, input logic [15:0] d,
                         output int lat, output bit flt, output bit we_seen);
        bit both;
        lat = 0; flt = 0; we_seen = 0; both = 0;
        req = 1'b1; op = o; wide = w; wdata = d;
        for (int c = 1; c <= 50; c++) begin
            tick();
            req = 1'b0;
            if (mem_we) we_seen = 1;
            if (mem_we && mem_re) both = 1;
            if (done) begin
                lat = c;
                flt = fault;
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL op_timeout: got no done expected done within 50 cycles");
        end
        chk("we_re_exclusive", {31'd0, both}, 32'd0);
    endtask

    initial begin
        int  lat;
        bit  flt;
        bit  wes;
        bit  bad;
        logic [15:0] hold_addr;

        tv[0] = '{1, 16'hFFFF, 0, 1, 16'hBEEF, 16'hFFFD, 16'h0000, 3};
        tv[1] = '{0, 16'h0000, 1, 1, 16'h0000, 16'hFFFF, 16'hBEEF, 3};
        tv[2] = '{1, 16'hFF80, 0, 0, 16'h1234, 16'hFF7F, 16'hBEEF, 2};
        tv[3] = '{0, 16'h0000, 0, 1, 16'hCAFE, 16'hFF7D, 16'hBEEF, 3};
        tv[4] = '{0, 16'h0000, 1, 0, 16'h0000, 16'hFF7E, 16'h00FE, 2};
        tv[5] = '{0, 16'h0000, 1, 1, 16'h0000, 16'hFF80, 16'h34CA, 3};
        tv[6] = '{1, 16'hFF05, 0, 1, 16'h0102, 16'hFF03, 16'h34CA, 3};
        tv[7] = '{0, 16'h0000, 1, 1, 16'h0000, 16'hFF05, 16'h0102, 3};

        reset = 1'b1; req = 1'b0; op = 1'b0; wide = 1'b0; wdata = 16'h0;
        load_sp = 1'b0; sp_in = 16'h0; mem_ready = 1'b1;
        #3;
        chk("rst_sp",    {16'd0, sp}, 32'h0000FFFF);
        chk("rst_flags", {26'd0, busy, done, fault, mem_we, mem_re, 1'b0}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_addr",  {8'd0, mem_addr, mem_wdata}, 32'd0);
        #10;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (tv[i].ld) load(tv[i].ld_val);
            do_op(tv[i].op, tv[i].wide, tv[i].wdata, lat, flt, wes);
            chk($sformatf("v%0d_lat", i),   lat, tv[i].exp_lat);
            chk($sformatf("v%0d_sp", i),    {16'd0, sp}, {16'd0, tv[i].exp_sp});
            chk($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, tv[i].exp_rdata});
            chk($sformatf("v%0d_fault", i), {31'd0, flt}, 32'd0);
            if (i == 0) begin
                chk("v0_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'hBE);
                chk("v0_mem_fffe", {24'd0, mem[16'hFFFE]}, 32'hEF);
            end
            tick();
            chk($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd0);
        end
        chk("v3_mem_ff7e", {24'd0, mem[16'hFF7E]}, 32'hFE);

        // Pop stalled by mem_ready low for 4 cycles.
        load(16'hFF51);
        do_op(1'b0, 1'b0, 16'h005A, lat, flt, wes);
        chk("stall_setup_sp", {16'd0, sp}, 32'h0000FF50);
        tick();
        mem_ready = 1'b0;
        req = 1'b1; op = 1'b1; wide = 1'b0;
        tick();
        req = 1'b0;
        hold_addr = mem_addr;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (!mem_re || mem_we || mem_addr !== 16'hFF51 || done) bad = 1;
            tick();
        end
        mem_ready = 1'b1;
        chk("stall_addr", {16'd0, hold_addr}, 32'h0000FF51);
        chk("stall_hold", {31'd0, bad}, 32'd0);
        chk("stall_re_5th", {31'd0, mem_re}, 32'd1);
        tick();
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_rdata", {16'd0, rdata}, 32'h0000005A);
        chk("stall_sp", {16'd0, sp}, 32'h0000FF51);
        tick();

        // load_sp wins over a simultaneous req.
        load_sp = 1'b1; sp_in = 16'h1234; req = 1'b1; op = 1'b0; wide = 1'b1;
        tick();
        load_sp = 1'b0; req = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_we || mem_re || done || busy) bad = 1;
            tick();
        end
        chk("ldpri_sp", {16'd0, sp}, 32'h00001234);
        chk("ldpri_quiet", {31'd0, bad}, 32'd0);

        // Reset while in WR_LO: first byte stays in memory, second never written.
        load(16'hFFFF);
        req = 1'b1; op = 1'b0; wide = 1'b1; wdata = 16'h1122;
        tick();
        req = 1'b0;
        tick();
        chk("abort_in_wrlo", {31'd0, mem_we}, 32'd1);
        chk("abort_addr", {16'd0, mem_addr}, 32'h0000FFFE);
        reset = 1'b1;
        #1;
        chk("abort_we_drop", {31'd0, mem_we}, 32'd0);
        chk("abort_sp", {16'd0, sp}, 32'h0000FFFF);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) bad = 1;
            tick();
        end
        chk("abort_no_done", {31'd0, bad}, 32'd0);
        chk("abort_mem_hi", {24'd0, mem[16'hFFFF]}, 32'h11);
        chk("abort_mem_lo", {24'd0, mem[16'hFFFE]}, 32'hEF);

`ifdef STACK_GUARD_EN
        load(16'hFF00);
        do_op(1'b0, 1'b1, 16'hABCD, lat, flt, wes);
        chk("guard_push_fault", {31'd0, flt}, 32'd1);
        chk("guard_push_lat", lat, 1);
        chk("guard_push_nowe", {31'd0, wes}, 32'd0);
        chk("guard_push_sp", {16'd0, sp}, 32'h0000FF00);
        tick();
        load(16'hFFFF);
        do_op(1'b1, 1'b0, 16'h0000, lat, flt, wes);
        chk("guard_pop_fault", {31'd0, flt}, 32'd1);
        chk("guard_pop_sp", {16'd0, sp}, 32'h0000FFFF);
        tick();
`else
        // Wrap-around: pop at FFFF reads address 0000; push at 0000 wraps back to FFFF.
        load(16'hFFFF);
        do_op(1'b1, 1'b0, 16'h0000, lat, flt, wes);
        chk("wrap_pop_rdata", {16'd0, rdata}, 32'h00000000);
        chk("wrap_pop_sp", {16'd0, sp}, 32'h00000000);
        chk("wrap_pop_fault", {31'd0, flt}, 32'd0);
        tick();
        do_op(1'b0, 1'b0, 16'h00AB, lat, flt, wes);
        chk("wrap_push_sp", {16'd0, sp}, 32'h0000FFFF);
        chk("wrap_push_mem", {24'd0, mem[16'h0000]}, 32'hAB);
        chk("wrap_push_rdata", {16'd0, rdata}, 32'h00000000);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
